frame_drawer: RTL and testbench



---
 rtl/frame_drawer.sv | 149 ++++++++++++++
 tb/tb_frame_drawer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_drawer.sv
// Purpose: streams one image from an external ROM to a VGA adapter, one pixel per clock, in x-major order.
// Latency: the first plot comes ROM_LATENCY cycles after DRAW entry; done pulses one cycle after the last plot.
// Backpressure: none. The frame free-runs once started, and start is ignored while busy. Optional FRAME_DRAWER_TRANSPARENT_EN suppresses plots of black pixels.
module frame_drawer #(
    parameter int WIDTH       = 160,
    parameter int HEIGHT      = 120,
    parameter int ROM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  imageSel,
    input  logic [2:0]  iColour,
    output logic [14:0] address,
    output logic [7:0]  chipSelect,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        busy,
    output logic        done
);

    localparam int TOTAL = WIDTH * HEIGHT;
    // Flush counter only needs to reach ROM_LATENCY-1; keep at least one bit.
    localparam int FW    = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, DRAW, FLUSH, DONE} state_t;

    state_t        state_q, state_d;
    logic [14:0]   addr_q;
    logic [7:0]    ax_q;
    logic [6:0]    ay_q;
    logic [7:0]    sel_q;
    logic [FW-1:0] flush_q;
    logic          last_addr;
    logic          flush_end;

    // The x/y/plot pipeline mirrors the ROM read latency so that the outputs line up with iColour.
    logic          pipe_v [ROM_LATENCY];
    logic [7:0]    pipe_x [ROM_LATENCY];
    logic [6:0]    pipe_y [ROM_LATENCY];

    assign last_addr = (addr_q == 15'(TOTAL - 1));
    assign flush_end = (flush_q == FW'(ROM_LATENCY - 1));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. start only matters in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)     state_d = DRAW;
            DRAW:    if (last_addr) state_d = FLUSH;
            FLUSH:   if (flush_end) state_d = DONE;
            DONE:                   state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Address counters. The linear address and the x/y coordinates advance together, so no multiply is needed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            ax_q    <= '0;
            ay_q    <= '0;
            sel_q   <= '0;
            flush_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    flush_q <= '0;
                    if (start) begin
                        sel_q <= imageSel;
                    end
                end
                DRAW: begin
                    flush_q <= '0;
                    // Hold on the final address instead of wrapping.
                    if (!last_addr) begin
                        addr_q <= addr_q + 15'd1;
                        if (ax_q == 8'(WIDTH - 1)) begin
                            ax_q <= '0;
                            ay_q <= ay_q + 7'd1;
                        end else begin
                            ax_q <= ax_q + 8'd1;
                        end
                    end
                end
                FLUSH: begin
                    flush_q <= flush_q + FW'(1);
                end
                DONE: begin
                    // Rewind here so that IDLE always presents address 0.
                    addr_q <= '0;
                    ax_q   <= '0;
                    ay_q   <= '0;
                end
                default: begin
                    addr_q <= '0;
                end
            endcase
        end
    end

    // Delay line for coordinates and the valid flag. Clearing it on reset kills any in-flight plots.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ROM_LATENCY; i++) begin
                pipe_v[i] <= 1'b0;
                pipe_x[i] <= '0;
                pipe_y[i] <= '0;
            end
        end else begin
            pipe_v[0] <= (state_q == DRAW);
            pipe_x[0] <= ax_q;
            pipe_y[0] <= ay_q;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_x[i] <= pipe_x[i-1];
                pipe_y[i] <= pipe_y[i-1];
            end
        end
    end

    // Output decode. The black image (select 0) is shown whenever no frame is being fetched.
    always_comb begin
        address    = addr_q;
        chipSelect = ((state_q == DRAW) || (state_q == FLUSH)) ? sel_q : 8'd0;
        x          = pipe_x[ROM_LATENCY-1];
        y          = pipe_y[ROM_LATENCY-1];
        colour     = iColour;
        busy       = (state_q != IDLE);
        done       = (state_q == DONE);
`ifdef FRAME_DRAWER_TRANSPARENT_EN
        plot       = pipe_v[ROM_LATENCY-1] && (iColour != 3'b000);
`else
        plot       = pipe_v[ROM_LATENCY-1];
`endif
    end

endmodule

// File: tb/tb_frame_drawer.sv
// Bench for frame_drawer: a latency-2 ROM model, a pixel scoreboard, and per-cycle timing expectations.
// Expected pixels are queued when a frame starts; the monitor pops one of them on every plot.
// Covers reset, full frames, a start issued mid-frame, a reset mid-frame and the row wrap.
module tb_frame_drawer;

    localparam int W = 160;
    localparam int H = 120;
    localparam int L = 2;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  imageSel;
    logic [2:0]  iColour;
    logic [14:0] address;
    logic [7:0]  chipSelect;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        busy;
    logic        done;

    frame_drawer #(.WIDTH(W), .HEIGHT(H), .ROM_LATENCY(L)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .imageSel   (imageSel),
        .iColour    (iColour),
        .address    (address),
        .chipSelect (chipSelect),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // ROM contents: a function of the address and a per-frame key.
    logic [2:0] key = 3'd0;
    function automatic logic [2:0] rom_f(input logic [14:0] a, input logic [2:0] k);
`ifdef FRAME_DRAWER_TRANSPARENT_EN
        return a[0] ? {a[2:1] ^ k[2:1], 1'b1} : 3'b000;
`else
        return a[2:0] ^ k;
`endif
    endfunction

    logic [2:0] r1 = 3'd0;
    logic [2:0] r2 = 3'd0;
    always @(posedge clk) begin
        r1 <= rom_f(address, key);
        r2 <= r1;
    end
    assign iColour = r2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int px;
        int py;
        int pc;
    } pix_t;
    pix_t sb[$];

    bit         active = 1'b0;
    int         t0 = 0;
    logic [7:0] exp_sel = 8'd0;
    logic [2:0] fkey = 3'd0;
    int         frames_done = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: derives the frame timeline from the cycle offset since DRAW entry and scoreboards the plotted pixels.
    always @(negedge clk) begin
        int   t;
        int   pa;
        bit   win;
        bit   exp_plot;
        pix_t e;
        if (active) begin
            t   = cyc - t0;
            pa  = t - L;
            win = (t >= L) && (t < N + L);
            exp_plot = win;
`ifdef FRAME_DRAWER_TRANSPARENT_EN
            if (win) exp_plot = (rom_f(15'(pa), fkey) != 3'b000);
`endif
            chk("busy", int'(busy), 1);
            chk("chipSelect", int'(chipSelect), (t < N + L) ? int'(exp_sel) : 0);
            chk("done", int'(done), (t == N + L) ? 1 : 0);
            if (t < N) chk("address", int'(address), t);
            else if (t < N + L) chk("address_hold", int'(address), N - 1);
            chk("plot", int'(plot), int'(exp_plot));
            if (plot) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("pix_x", int'(x), e.px);
                    chk("pix_y", int'(y), e.py);
                    chk("pix_colour", int'(colour), e.pc);
                end
            end
            if (t == N + L) begin
                chk("sb_empty_at_done", sb.size(), 0);
                frames_done++;
                active = 1'b0;
            end
        end else begin
            chk("idle_busy", int'(busy), 0);
            chk("idle_done", int'(done), 0);
            chk("idle_plot", int'(plot), 0);
            chk("idle_address", int'(address), 0);
            chk("idle_chipSelect", int'(chipSelect), 0);
        end
    end

    task automatic start_frame(input logic [7:0] sel, input logic [2:0] k);
        logic [2:0] c;
        @(posedge clk); #1;
        key      = k;
        imageSel = sel;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        imageSel = 8'($urandom);
        t0       = cyc;
        exp_sel  = sel;
        fkey     = k;
        for (int a = 0; a < N; a++) begin
            c = rom_f(15'(a), k);
`ifdef FRAME_DRAWER_TRANSPARENT_EN
            if (c == 3'b000) continue;
`endif
            sb.push_back('{a % W, a / W, int'(c)});
        end
        active = 1'b1;
    endtask

    task automatic wait_frame_end();
        for (int i = 0; i < N + L + 20 && active; i++) @(posedge clk);
        if (active) begin
            chk("frame_timeout", 0, 1);
            active = 1'b0;
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        bit found;
        reset    = 1'b1;
        start    = 1'b0;
        imageSel = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_address", int'(address), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_plot", int'(plot), 0);
        chk("rst_x", int'(x), 0);
        chk("rst_y", int'(y), 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // Frame 1: image 1 with colour = address[2:0]. A second start for image 3 arrives mid-frame and must be ignored.
        start_frame(8'd1, 3'd0);
        repeat ($urandom_range(100, 2000)) @(posedge clk);
        #1;
        imageSel = 8'd3;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        wait_frame_end();
        chk("done_count_f1", frames_done, 1);
        repeat (4) @(posedge clk);
        chk("done_count_f1_idle", frames_done, 1);

        // Frame 2: aborted by a reset at address 5000.
        start_frame(8'($urandom_range(1, 255)), 3'($urandom));
        found = 1'b0;
        for (int i = 0; i < 6000 && !found; i++) begin
            @(negedge clk);
            if (address == 15'd5000) found = 1'b1;
        end
        chk("reach_5000", int'(found), 1);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_plot", int'(plot), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_address", int'(address), 0);
        chk("abort_chipSelect", int'(chipSelect), 0);
        chk("abort_done", int'(done), 0);
        active = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (6) @(posedge clk);
        chk("done_count_abort", frames_done, 1);

        // Frame 3: a fresh frame after the abort, with a random image and key.
        start_frame(8'($urandom), 3'($urandom));
        wait_frame_end();
        chk("done_count_f3", frames_done, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
